// File: rtl/vector_exec_seq_if.sv
// +--------------------------------------------------------------------------+
// | vector_exec_seq_if : launch/result bundle between VRF ports and exec unit |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

interface vector_exec_seq_if #(
  parameter int NELEM = 5,
  parameter int W     = 32
);
  logic                 start;
  logic [2:0]           op;
  logic [3:0]           vd_in;
  logic                 use_scalar;
  logic [NELEM*W-1:0]   va;
  logic [NELEM*W-1:0]   vb;
  logic [W-1:0]         scalar_b;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic                 vwe;
  logic [3:0]           vd_out;
  logic [NELEM*W-1:0]   vres;
  logic [W-1:0]         sres;

  modport master (
    output start, op, vd_in, use_scalar, va, vb, scalar_b,
    input  busy, done, err, vwe, vd_out, vres, sres
  );

  modport slave (
    input  start, op, vd_in, use_scalar, va, vb, scalar_b,
    output busy, done, err, vwe, vd_out, vres, sres
  );
endinterface

`default_nettype wire

// File: rtl/vector_exec_seq.sv
// +--------------------------------------------------------------------------+
// | vector_exec_seq : element-serial vector ALU with packed write-back       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module vector_exec_seq #(
  parameter int NELEM = 5,
  parameter int W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  vector_exec_seq_if.slave bus
);

  localparam int IW = (NELEM > 1) ? $clog2(NELEM) : 1;
  localparam int VW = NELEM * W;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_WB   = 2'd2;

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_AND = 3'b010;
  localparam logic [2:0] c_OP_ORR = 3'b011;
  localparam logic [2:0] c_OP_MUL = 3'b100;
  localparam logic [2:0] c_OP_SUM = 3'b101;
  localparam logic [2:0] c_OP_MAX = 3'b110;
  localparam logic [2:0] c_OP_ILL = 3'b111;

  localparam logic [IW-1:0] c_LAST = IW'(NELEM - 1);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [IW-1:0] r_idx;
  logic [VW-1:0] r_a;
  logic [VW-1:0] r_b;
  logic [2:0]    r_op;
  logic [3:0]    r_vd;
  logic [VW-1:0] r_res;
  logic [VW-1:0] r_vres;
  logic [W-1:0]  r_acc;
  logic [W-1:0]  r_sres;

  int            w_base;
  logic [W-1:0]  w_ea;
  logic [W-1:0]  w_eb;
  logic [W-1:0]  w_elem;
  logic [W-1:0]  w_acc_nxt;
  logic [VW-1:0] w_res_final;
  logic          w_last;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (bus.start) w_state_nxt = c_RUN;
      c_RUN:   if (w_last)    w_state_nxt = c_WB;
      c_WB:    w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    bus.err    = 1'b0;
    bus.vwe    = 1'b0;
    bus.vd_out = 4'd0;
    case (r_state)
      c_RUN: bus.busy = 1'b1;
      c_WB: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        if (r_op == c_OP_ILL) begin
          bus.err = 1'b1;
        end else if (r_op != c_OP_SUM) begin
          bus.vwe    = 1'b1;
          bus.vd_out = r_vd;
        end
      end
      default: ;
    endcase
  end

  assign bus.vres = r_vres;
  assign bus.sres = r_sres;

  // Element datapath; the final slot is merged combinationally so vres loads whole on WB entry
  always_comb begin
    w_base    = int'(r_idx) * W;
    w_ea      = r_a[w_base +: W];
    w_eb      = r_b[w_base +: W];
    w_last    = (r_idx == c_LAST);
    w_acc_nxt = r_acc + w_ea;
    w_elem    = '0;
    case (r_op)
      c_OP_ADD: w_elem = w_ea + w_eb;
      c_OP_SUB: w_elem = w_ea - w_eb;
      c_OP_AND: w_elem = w_ea & w_eb;
      c_OP_ORR: w_elem = w_ea | w_eb;
      c_OP_MUL: w_elem = w_ea * w_eb;
      c_OP_MAX: w_elem = ($signed(w_ea) > $signed(w_eb)) ? w_ea : w_eb;
      default:  w_elem = '0;
    endcase
    w_res_final                = r_res;
    w_res_final[w_base +: W]   = w_elem;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= '0;
      r_vd   <= '0;
      r_res  <= '0;
      r_vres <= '0;
      r_acc  <= '0;
      r_sres <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.start) begin
            r_a   <= bus.va;
            r_b   <= bus.use_scalar ? {NELEM{bus.scalar_b}} : bus.vb;
            r_op  <= bus.op;
            r_vd  <= bus.vd_in;
            r_idx <= '0;
            r_acc <= '0;
          end
        end
        c_RUN: begin
          r_res[w_base +: W] <= w_elem;
          r_acc              <= w_acc_nxt;
          if (w_last) begin
            r_idx <= '0;
            if (r_op == c_OP_SUM) begin
              r_sres <= w_acc_nxt;
            end else if (r_op != c_OP_ILL) begin
              r_vres <= w_res_final;
            end
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
